// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester and BRAM-side signal bundle for bram_port_arbiter
interface bram_port_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITW = 32,
    parameter int DATA_BITW = 32
);
    localparam int BE_BITW = DATA_BITW / 8;

    logic [NUM_REQ-1:0]           Req_SI;
    logic [NUM_REQ-1:0]           Lock_SI;
    logic [NUM_REQ*ADDR_BITW-1:0] Addr_DI;
    logic [NUM_REQ*BE_BITW-1:0]   WrEn_SI;
    logic [NUM_REQ*DATA_BITW-1:0] Wr_DI;
    logic [NUM_REQ-1:0]           Gnt_SO;
    logic [NUM_REQ-1:0]           RdVal_SO;
    logic [DATA_BITW-1:0]         Rd_DO;
    logic                         Bram_En_SO;
    logic [ADDR_BITW-1:0]         Bram_Addr_SO;
    logic [BE_BITW-1:0]           Bram_WrEn_SO;
    logic [DATA_BITW-1:0]         Bram_Wr_DO;
    logic [DATA_BITW-1:0]         Bram_Rd_DI;

    modport slave (
        input  Req_SI, Lock_SI, Addr_DI, WrEn_SI, Wr_DI, Bram_Rd_DI,
        output Gnt_SO, RdVal_SO, Rd_DO, Bram_En_SO, Bram_Addr_SO, Bram_WrEn_SO, Bram_Wr_DO
    );

    modport master (
        output Req_SI, Lock_SI, Addr_DI, WrEn_SI, Wr_DI, Bram_Rd_DI,
        input  Gnt_SO, RdVal_SO, Rd_DO, Bram_En_SO, Bram_Addr_SO, Bram_WrEn_SO, Bram_Wr_DO
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin BRAM port arbiter with lock and read-owner tracking
module bram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_BITW  = 32,
    parameter int DATA_BITW  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    bram_port_arbiter_if.slave   bus
);
    localparam int BE_BITW  = DATA_BITW / 8;
    localparam int IDX_BITW = $clog2(NUM_REQ);

    typedef logic [IDX_BITW-1:0] idx_t;

    idx_t                  r_ptr;
    logic                  r_lock_vld;
    idx_t                  r_lock_own;
    logic [RD_LATENCY-1:0] r_rd_vld;
    idx_t                  r_rd_own [RD_LATENCY];

    logic                  w_gnt_vld;
    logic                  w_gnt_act;
    idx_t                  w_gnt_idx;
    idx_t                  w_scan_idx;
    idx_t                  w_ptr_nxt;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [NUM_REQ-1:0]    w_rd_val;
    logic [BE_BITW-1:0]    w_gnt_wren;
    logic                  w_gnt_rd;
    int                    w_scan_pos;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_scan_pos = 0;
        w_scan_idx = '0;
        if (r_lock_vld && bus.Req_SI[r_lock_own]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = r_lock_own;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_scan_pos = int'(r_ptr) + k;
                if (w_scan_pos >= NUM_REQ) begin
                    w_scan_pos = w_scan_pos - NUM_REQ;
                end
                w_scan_idx = idx_t'(w_scan_pos);
                if (bus.Req_SI[w_scan_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_scan_idx;
                end
            end
        end
    end

    assign w_gnt_act  = w_gnt_vld && Rst_RBI;
    assign w_gnt_wren = bus.WrEn_SI[int'(w_gnt_idx)*BE_BITW +: BE_BITW];
    assign w_gnt_rd   = w_gnt_act && (w_gnt_wren == '0);
    assign w_ptr_nxt  = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_gnt_oh = '0;
        if (w_gnt_act) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (r_rd_vld[RD_LATENCY-1]) begin
            w_rd_val[r_rd_own[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign bus.Gnt_SO       = w_gnt_oh;
    assign bus.Bram_En_SO   = w_gnt_act;
    assign bus.Bram_Addr_SO = bus.Addr_DI[int'(w_gnt_idx)*ADDR_BITW +: ADDR_BITW];
    assign bus.Bram_Wr_DO   = bus.Wr_DI[int'(w_gnt_idx)*DATA_BITW +: DATA_BITW];
    assign bus.Bram_WrEn_SO = w_gnt_act ? w_gnt_wren : '0;
    assign bus.RdVal_SO     = w_rd_val;
    assign bus.Rd_DO        = bus.Bram_Rd_DI;

    // The owner pipeline mirrors the BRAM read latency so each return is tagged.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_ptr      <= '0;
            r_lock_vld <= 1'b0;
            r_lock_own <= '0;
            r_rd_vld   <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_rd_own[s] <= '0;
            end
        end else begin
            if (w_gnt_vld) begin
                r_ptr      <= w_ptr_nxt;
                r_lock_vld <= bus.Lock_SI[w_gnt_idx];
                r_lock_own <= w_gnt_idx;
            end else begin
                r_lock_vld <= 1'b0;
            end
            r_rd_vld[0] <= w_gnt_rd;
            r_rd_own[0] <= w_gnt_idx;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_rd_vld[s] <= r_rd_vld[s-1];
                r_rd_own[s] <= r_rd_own[s-1];
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;
    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NUM_REQ(N), .ADDR_BITW(AW), .DATA_BITW(DW)) bus ();

    bram_port_arbiter #(
        .NUM_REQ(N), .ADDR_BITW(AW), .DATA_BITW(DW), .RD_LATENCY(LAT)
    ) dut (
        .Clk_CI(clk),
        .Rst_RBI(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          own;
        logic [31:0] data;
        int          due;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        req  [N];
    logic        lock [N];
    logic [31:0] addr [N];
    logic [3:0]  wren [N];
    logic [31:0] wr   [N];

    int          p_req, p_lock, p_rd;
    logic [N-1:0] act_mask;

    int          m_ptr;
    int          m_lock_own;
    bit          m_lock_v;
    logic [31:0] shadow [16];
    exp_t        exp_q [$];

    function automatic logic [31:0] init_val(int i);
        return 32'hA5A5A5A5 ^ (32'h01010101 * i);
    endfunction

    // Environment BRAM with LAT-cycle registered read
    logic [31:0] mem [16];
    logic [31:0] rd_pipe [LAT];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.Bram_En_SO) begin
            if (bus.Bram_WrEn_SO == '0) begin
                rd_pipe[0] <= mem[bus.Bram_Addr_SO[5:2]];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (bus.Bram_WrEn_SO[b])
                        mem[bus.Bram_Addr_SO[5:2]][8*b +: 8] <= bus.Bram_Wr_DO[8*b +: 8];
            end
        end
        for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bus.Bram_Rd_DI = rd_pipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_txn(input int i);
        req[i]  = act_mask[i] && ($urandom_range(99) < p_req);
        lock[i] = ($urandom_range(99) < p_lock);
        addr[i] = {26'd0, 4'($urandom_range(15)), 2'b00};
        wren[i] = ($urandom_range(99) < p_rd) ? 4'd0 : 4'($urandom_range(1, 15));
        wr[i]   = $urandom;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.Req_SI[i]              = req[i];
            bus.Lock_SI[i]             = lock[i];
            bus.Addr_DI[i*AW +: AW]    = addr[i];
            bus.WrEn_SI[i*BW +: BW]    = wren[i];
            bus.Wr_DI[i*DW +: DW]      = wr[i];
        end
    endtask

    task automatic step();
        int g;
        int j;
        exp_t e;
        @(negedge clk);
        g = -1;
        if (m_lock_v && req[m_lock_own]) begin
            g = m_lock_own;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (req[j]) begin
                    g = j;
                    break;
                end
            end
        end
        check("gnt", 64'(bus.Gnt_SO), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("bram_en", 64'(bus.Bram_En_SO), 64'(g >= 0));
        check("bram_wren", 64'(bus.Bram_WrEn_SO), (g >= 0) ? 64'(wren[g]) : 64'd0);
        if (g >= 0) begin
            check("bram_addr", 64'(bus.Bram_Addr_SO), 64'(addr[g]));
            if (wren[g] != 4'd0) check("bram_wr", 64'(bus.Bram_Wr_DO), 64'(wr[g]));
            m_ptr      = (g + 1) % N;
            m_lock_v   = lock[g];
            m_lock_own = g;
            if (wren[g] == 4'd0) begin
                e.own  = g;
                e.data = shadow[addr[g][5:2]];
                e.due  = cyc + LAT;
                exp_q.push_back(e);
            end else begin
                for (int b = 0; b < BW; b++)
                    if (wren[g][b]) shadow[addr[g][5:2]][8*b +: 8] = wr[g][8*b +: 8];
            end
        end else begin
            m_lock_v = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (i == g || !req[i]) new_txn(i);
        drive();
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        exp_q.delete();
        m_ptr      = 0;
        m_lock_v   = 1'b0;
        m_lock_own = 0;
        for (int i = 0; i < N; i++)
            if (!req[i]) begin
                new_txn(i);
                req[i] = 1'b1;
            end
        drive();
        repeat (ncyc) begin
            @(negedge clk);
            check("rst_gnt", 64'(bus.Gnt_SO), 64'd0);
            check("rst_bram_en", 64'(bus.Bram_En_SO), 64'd0);
            check("rst_rdval", 64'(bus.RdVal_SO), 64'd0);
            @(posedge clk);
            cyc++;
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Read-return monitor: pops expected reads when due or when RdVal shows up
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.RdVal_SO != '0 || (exp_q.size() > 0 && exp_q[0].due == cyc)) begin
                if (exp_q.size() == 0) begin
                    check("rdval_unexpected", 64'(bus.RdVal_SO), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdval", 64'(bus.RdVal_SO), 64'd1 << e.own);
                    check("rd_data", 64'(bus.Rd_DO), 64'(e.data));
                    check("rd_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        m_ptr = 0; m_lock_v = 1'b0; m_lock_own = 0;
        p_req = 100; p_lock = 0; p_rd = 100; act_mask = '1;
        for (int i = 0; i < N; i++) new_txn(i);
        drive();
        #1;
        do_reset(3);

        repeat (12) step();
        p_rd = 50;
        repeat (20) step();
        p_lock = 60; p_req = 90;
        repeat (40) step();

        act_mask = 3'b001; p_lock = 0; p_req = 100;
        req[1] = 1'b0; req[2] = 1'b0; drive();
        repeat (10) step();

        act_mask = '1; p_req = 70; p_lock = 25; p_rd = 50;
        repeat (300) step();

        p_rd = 100; p_req = 100; p_lock = 0;
        repeat (3) step();
        do_reset(2);
        repeat (10) step();

        p_req = 0;
        for (int i = 0; i < N; i++) req[i] = 1'b0;
        drive();
        repeat (LAT + 3) step();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
